// File: rtl/uart_rx_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_parser_if
// Bundles the RX FIFO read port and the decoded-frame output bus of
// uart_rx_frame_parser.
//   master : the parser. Reads the FIFO and drives signal words and status.
//   slave  : the environment. Drives the FIFO flags/data and consumes outputs.
// Signals:
//   rx_fifo_empty / rx_fifo_ren / rx_fifo_rdata : non-showahead FIFO read port
//   sig_wen, sig_idx, sig_dig, sig_data         : decoded signal word strobe
//   cnt_10ms                                    : timestamp of last good frame
//   frame_done, frame_err, err_code, seq_err    : frame status
//   frame_cnt, err_cnt                          : wrapping frame counters
// ---------------------------------------------------------------------------
interface uart_rx_frame_parser_if;
   logic        rx_fifo_empty;
   logic        rx_fifo_ren;
   logic [7:0]  rx_fifo_rdata;
   logic        sig_wen;
   logic [4:0]  sig_idx;
   logic        sig_dig;
   logic [13:0] sig_data;
   logic [15:0] cnt_10ms;
   logic        frame_done;
   logic        frame_err;
   logic [2:0]  err_code;
   logic        seq_err;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   modport master (
      input  rx_fifo_empty, rx_fifo_rdata,
      output rx_fifo_ren, sig_wen, sig_idx, sig_dig, sig_data, cnt_10ms,
             frame_done, frame_err, err_code, seq_err, frame_cnt, err_cnt
   );

   modport slave (
      output rx_fifo_empty, rx_fifo_rdata,
      input  rx_fifo_ren, sig_wen, sig_idx, sig_dig, sig_data, cnt_10ms,
             frame_done, frame_err, err_code, seq_err, frame_cnt, err_cnt
   );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_parser
// Pops bytes from a non-showahead UART RX FIFO, hunts for the 32-bit frame
// header (sent LSB byte first), validates the frame fields and streams the
// decoded signal words. Reports frame completion, aborts with a cause code,
// and timestamp sequence gaps.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   ena  : parser enable; low = no FIFO reads, state held
//   bus  : uart_rx_frame_parser_if.master (FIFO port + decoded outputs)
// Error codes: 1 num_signal, 2 word index, 3 type byte, 4 digital value,
//              5 analog value.
// ---------------------------------------------------------------------------
module uart_rx_frame_parser #(
   parameter logic [31:0] HEAD        = 32'h7FFF7FFF,
   parameter int          NUM_SIGNAL  = 16,
   parameter int          NUM_DIGITAL = 2,
   parameter logic [7:0]  TYPE_DIG    = 8'h33,
   parameter logic [7:0]  TYPE_ANA    = 8'hCC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   uart_rx_frame_parser_if.master bus
);

   typedef enum logic [1:0] {HUNT, HDR, SIG} state_t;

   // Oldest received byte ends up in the MSBs of the window.
   localparam logic [31:0] HEAD_WIN = {HEAD[7:0], HEAD[15:8], HEAD[23:16], HEAD[31:24]};
   localparam logic [15:0] NSIG16   = 16'(NUM_SIGNAL);
   localparam logic [4:0]  LAST_W   = 5'(NUM_SIGNAL - 1);
   localparam logic [4:0]  NDIG5    = 5'(NUM_DIGITAL);

   state_t      state_q, state_d;
   logic        rd_val_q;
   logic [31:0] win_q, win_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [4:0]  word_q, word_d;
   logic [15:0] ts_q, ts_d;
   logic [7:0]  tmp_q, tmp_d;       // num_signal low byte, then b2 of a word
   logic        first_q, first_d;

   logic        wen_q, wen_d;
   logic [4:0]  idx_q, idx_d;
   logic        dig_q, dig_d;
   logic [13:0] data_q, data_d;
   logic [15:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [2:0]  code_q, code_d;
   logic        seq_q, seq_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [15:0] ecnt_q, ecnt_d;

   logic [7:0]  rx_b;
   logic [31:0] win_sh;
   logic        is_dig;
   logic        abort_c;
   logic [2:0]  abort_code_c;

   assign bus.rx_fifo_ren = ena & ~bus.rx_fifo_empty;
   assign rx_b   = bus.rx_fifo_rdata;
   assign win_sh = {win_q[23:0], rx_b};
   assign is_dig = (word_q < NDIG5);

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      bcnt_d       = bcnt_q;
      word_d       = word_q;
      ts_d         = ts_q;
      tmp_d        = tmp_q;
      first_d      = first_q;
      wen_d        = 1'b0;
      idx_d        = idx_q;
      dig_d        = dig_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      code_d       = code_q;
      seq_d        = 1'b0;
      fcnt_d       = fcnt_q;
      ecnt_d       = ecnt_q;
      abort_c      = 1'b0;
      abort_code_c = 3'd0;

      // Everything advances only on a received byte, so ena/empty gaps
      // change timing but never values.
      if (rd_val_q) begin
         case (state_q)
            HUNT: begin
               win_d = win_sh;
               if (win_sh == HEAD_WIN) begin
                  state_d = HDR;
                  bcnt_d  = 2'd0;
                  win_d   = '0;
               end
            end
            HDR: begin
               bcnt_d = bcnt_q + 2'd1;
               case (bcnt_q)
                  2'd0: ts_d[7:0]  = rx_b;
                  2'd1: ts_d[15:8] = rx_b;
                  2'd2: tmp_d      = rx_b;
                  default: begin
                     if ({rx_b, tmp_q} != NSIG16) begin
                        abort_c      = 1'b1;
                        abort_code_c = 3'd1;
                     end else begin
                        state_d = SIG;
                        word_d  = 5'd0;
                     end
                  end
               endcase
            end
            SIG: begin
               bcnt_d = bcnt_q + 2'd1;
               case (bcnt_q)
                  2'd0: begin
                     if (rx_b != {3'b000, word_q}) begin
                        abort_c      = 1'b1;
                        abort_code_c = 3'd2;
                     end
                  end
                  2'd1: begin
                     if (rx_b != (is_dig ? TYPE_DIG : TYPE_ANA)) begin
                        abort_c      = 1'b1;
                        abort_code_c = 3'd3;
                     end
                  end
                  2'd2: begin
                     tmp_d = rx_b;
                     if (is_dig && (rx_b > 8'd1)) begin
                        abort_c      = 1'b1;
                        abort_code_c = 3'd4;
                     end
                  end
                  default: begin
                     if (is_dig && (rx_b != 8'd0)) begin
                        abort_c      = 1'b1;
                        abort_code_c = 3'd4;
                     end else if (!is_dig && (rx_b[7:6] != 2'b00)) begin
                        abort_c      = 1'b1;
                        abort_code_c = 3'd5;
                     end else begin
                        wen_d  = 1'b1;
                        idx_d  = word_q;
                        dig_d  = is_dig;
                        data_d = is_dig ? {13'd0, tmp_q[0]} : {rx_b[5:0], tmp_q};
                        if (word_q == LAST_W) begin
                           done_d  = 1'b1;
                           cnt_d   = ts_q;
                           fcnt_d  = fcnt_q + 16'd1;
                           // First good frame has no predecessor to compare.
                           seq_d   = !first_q && (ts_q != cnt_q + 16'd1);
                           first_d = 1'b0;
                           state_d = HUNT;
                        end else begin
                           word_d = word_q + 5'd1;
                        end
                     end
                  end
               endcase
            end
            default: state_d = HUNT;
         endcase

         if (abort_c) begin
            err_d   = 1'b1;
            code_d  = abort_code_c;
            ecnt_d  = ecnt_q + 16'd1;
            state_d = HUNT;
            win_d   = '0;
            bcnt_d  = 2'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= HUNT;
         rd_val_q <= 1'b0;
         win_q    <= '0;
         bcnt_q   <= '0;
         word_q   <= '0;
         ts_q     <= '0;
         tmp_q    <= '0;
         first_q  <= 1'b1;
         wen_q    <= 1'b0;
         idx_q    <= '0;
         dig_q    <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= '0;
         seq_q    <= 1'b0;
         fcnt_q   <= '0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         rd_val_q <= bus.rx_fifo_ren;
         win_q    <= win_d;
         bcnt_q   <= bcnt_d;
         word_q   <= word_d;
         ts_q     <= ts_d;
         tmp_q    <= tmp_d;
         first_q  <= first_d;
         wen_q    <= wen_d;
         idx_q    <= idx_d;
         dig_q    <= dig_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         code_q   <= code_d;
         seq_q    <= seq_d;
         fcnt_q   <= fcnt_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign bus.sig_wen    = wen_q;
   assign bus.sig_idx    = idx_q;
   assign bus.sig_dig    = dig_q;
   assign bus.sig_data   = data_q;
   assign bus.cnt_10ms   = cnt_q;
   assign bus.frame_done = done_q;
   assign bus.frame_err  = err_q;
   assign bus.err_code   = code_q;
   assign bus.seq_err    = seq_q;
   assign bus.frame_cnt  = fcnt_q;
   assign bus.err_cnt    = ecnt_q;

endmodule
